// File: rtl/fetch_unit.sv
// Instruction fetch stage: a PC register feeding a combinational imem,
// with a 2-deep {pc, instr} FIFO toward decode and redirect/fault handling.
module fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int          PC_INC   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fetch_en,
  output logic [63:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr,
  output logic        fault
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    IDLE  = 2'd1,
    FAULT = 2'd2
  } state_t;

  localparam logic [63:0] INC = 64'(PC_INC);

  state_t      state;
  logic [63:0] pc_q;
  logic [1:0]  count;
  logic [63:0] pc0, pc1;
  logic [31:0] in0, in1;

  logic push, pop, misaligned;

  assign imem_pc    = pc_q;
  assign out_valid  = (count != 2'd0);
  assign out_pc     = pc0;
  assign out_instr  = in0;
  assign fault      = (state == FAULT);
  assign misaligned = |redirect_pc[1:0];

  assign pop  = out_valid && out_ready && !redirect_valid;
  assign push = (state == RUN) && fetch_en && !redirect_valid
             && ((count != 2'd2) || pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= RUN;
      pc_q  <= RESET_PC;
      count <= 2'd0;
      pc0   <= '0;
      pc1   <= '0;
      in0   <= '0;
      in1   <= '0;
    end else if (redirect_valid) begin
      count <= 2'd0;
      if (misaligned) begin
        state <= FAULT;
      end else begin
        pc_q  <= redirect_pc;
        state <= RUN;
      end
    end else begin
      unique case (state)
        RUN:     if (!fetch_en) state <= IDLE;
        IDLE:    if (fetch_en) state <= RUN;
        default: state <= FAULT;
      endcase

      if (state == FAULT) begin
        count <= 2'd0;
      end else begin
        if (push) pc_q <= pc_q + INC;
        // Head is slot 0; a pop shifts slot 1 forward.
        unique case (1'b1)
          push && !pop: begin
            if (count == 2'd0) begin
              pc0 <= pc_q;
              in0 <= imem_instr;
            end else begin
              pc1 <= pc_q;
              in1 <= imem_instr;
            end
            count <= count + 2'd1;
          end
          !push && pop: begin
            pc0   <= pc1;
            in0   <= in1;
            count <= count - 2'd1;
          end
          push && pop: begin
            if (count == 2'd1) begin
              pc0 <= pc_q;
              in0 <= imem_instr;
            end else begin
              pc0 <= pc1;
              in0 <= in1;
              pc1 <= pc_q;
              in1 <= imem_instr;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: per-cycle vector table, hand sequences for
// redirect/fault/wrap/idle/async reset, and an in-order scoreboard.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        fetch_en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [63:0] redirect_pc = '0;
  logic        out_ready = 1'b0;
  logic [63:0] imem_pc;
  logic [31:0] imem_instr;
  logic        out_valid;
  logic [63:0] out_pc;
  logic [31:0] out_instr;
  logic        fault;

  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] sbq[$];
  bit sb_on = 1'b0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[33:2];
  endfunction

  assign imem_instr = mem_word(imem_pc);

  fetch_unit #(.RESET_PC(64'h0), .PC_INC(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .fetch_en(fetch_en),
    .imem_pc(imem_pc),
    .imem_instr(imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pc(out_pc),
    .out_instr(out_instr),
    .fault(fault)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s got %h want %h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic sb_restart(input logic [63:0] base);
    sbq.delete();
    for (int k = 0; k < 24; k++) sbq.push_back(base + 64'(4 * k));
  endtask

  task automatic drive(input bit en, input bit rdy, input bit rv,
                       input logic [63:0] rpc);
    fetch_en       = en;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic look(input string nm, input bit v, input logic [63:0] pc,
                      input logic [63:0] ipc);
    chk({nm, "_valid"}, 64'(out_valid), 64'(v));
    if (v) begin
      chk({nm, "_pc"}, out_pc, pc);
      chk({nm, "_instr"}, 64'(out_instr), 64'(mem_word(pc)));
    end
    chk({nm, "_imem_pc"}, imem_pc, ipc);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b1, 1'b1, 1'b0, '0);
    #1;
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_fault", 64'(fault), 64'd0);
    chk("rst_imem_pc", imem_pc, 64'h0);
    chk("rst_out_pc", out_pc, 64'h0);
    chk("rst_out_instr", 64'(out_instr), 64'h0);
    cyc();
    chk("rst_nopush_pc", imem_pc, 64'h0);
    chk("rst_nopush_valid", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    sb_restart(64'h0);
  endtask

  // Every accepted instruction must be the next one in fetch order.
  always @(negedge clk) begin : mon
    logic [63:0] e;
    if (sb_on && rst_n && out_valid && out_ready && !redirect_valid) begin
      n_cmp++;
      if (sbq.size() == 0) begin
        n_bad++;
        $display("FAIL sb_extra got pc=%h want none", out_pc);
      end else begin
        e = sbq.pop_front();
        if (out_pc !== e || out_instr !== mem_word(e)) begin
          n_bad++;
          $display("FAIL sb_order got pc=%h instr=%h want pc=%h instr=%h",
                   out_pc, out_instr, e, mem_word(e));
        end
      end
    end
  end

  typedef struct {
    bit          rst;
    bit          en;
    bit          rdy;
    bit          v;
    logic [63:0] pc;
    logic [63:0] ipc;
  } vec_t;

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{1'b1, 1'b1, 1'b1, 1'b1, 64'h0, 64'h4};
    tbl[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h4, 64'h8};
    tbl[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h8, 64'hC};
    tbl[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'hC, 64'h10};
    tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 64'h0, 64'h4};
    tbl[5]  = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 64'h8};
    tbl[6]  = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 64'h8};
    tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 64'h8};
    tbl[8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 64'h0, 64'h8};
    tbl[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h4, 64'hC};
    tbl[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'h8, 64'h10};
    tbl[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 64'hC, 64'h14};

    #1;
    sb_on = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].rst) do_reset();
      drive(tbl[i].en, tbl[i].rdy, 1'b0, '0);
      cyc();
      look($sformatf("vec%0d", i), tbl[i].v, tbl[i].pc, tbl[i].ipc);
    end

    // Redirect while full flushes queued entries.
    do_reset();
    drive(1'b1, 1'b0, 1'b0, '0);
    cyc();
    cyc();
    look("full", 1'b1, 64'h0, 64'h8);
    drive(1'b1, 1'b1, 1'b1, 64'h40);
    sb_restart(64'h40);
    cyc();
    look("flush", 1'b0, 64'h0, 64'h40);
    drive(1'b1, 1'b1, 1'b0, '0);
    cyc();
    look("redir", 1'b1, 64'h40, 64'h44);

    // Misaligned target faults; aligned redirect recovers.
    drive(1'b1, 1'b1, 1'b1, 64'h42);
    cyc();
    chk("flt_on", 64'(fault), 64'd1);
    look("flt0", 1'b0, 64'h0, 64'h44);
    drive(1'b1, 1'b1, 1'b0, '0);
    cyc();
    chk("flt_hold", 64'(fault), 64'd1);
    look("flt1", 1'b0, 64'h0, 64'h44);
    drive(1'b1, 1'b1, 1'b1, 64'h80);
    sb_restart(64'h80);
    cyc();
    chk("flt_off", 64'(fault), 64'd0);
    look("rec0", 1'b0, 64'h0, 64'h80);
    drive(1'b1, 1'b1, 1'b0, '0);
    cyc();
    look("rec1", 1'b1, 64'h80, 64'h84);

    // PC wraps modulo 2^64.
    drive(1'b1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
    sb_restart(64'hFFFF_FFFF_FFFF_FFFC);
    cyc();
    look("wrap0", 1'b0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFC);
    drive(1'b1, 1'b1, 1'b0, '0);
    cyc();
    look("wrap1", 1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'h0);
    cyc();
    look("wrap2", 1'b1, 64'h0, 64'h4);

    // Idle drains without fetching; resume costs one cycle.
    drive(1'b1, 1'b0, 1'b1, 64'h100);
    sb_restart(64'h100);
    cyc();
    look("idl0", 1'b0, 64'h0, 64'h100);
    drive(1'b1, 1'b0, 1'b0, '0);
    cyc();
    look("idl1", 1'b1, 64'h100, 64'h104);
    cyc();
    look("idl2", 1'b1, 64'h100, 64'h108);
    drive(1'b0, 1'b1, 1'b0, '0);
    cyc();
    look("idl3", 1'b1, 64'h104, 64'h108);
    cyc();
    look("idl4", 1'b0, 64'h0, 64'h108);
    cyc();
    look("idl5", 1'b0, 64'h0, 64'h108);
    drive(1'b1, 1'b1, 1'b0, '0);
    cyc();
    look("idl6", 1'b0, 64'h0, 64'h108);
    cyc();
    look("idl7", 1'b1, 64'h108, 64'h10C);

    // Asynchronous reset mid-stream with a full FIFO.
    drive(1'b1, 1'b0, 1'b1, 64'h200);
    sb_restart(64'h200);
    cyc();
    drive(1'b1, 1'b0, 1'b0, '0);
    cyc();
    cyc();
    look("arst_full", 1'b1, 64'h200, 64'h208);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(out_valid), 64'd0);
    chk("arst_pc", out_pc, 64'h0);
    chk("arst_instr", 64'(out_instr), 64'h0);
    chk("arst_imem", imem_pc, 64'h0);
    chk("arst_fault", 64'(fault), 64'd0);
    cyc();
    chk("arst_nopush", imem_pc, 64'h0);
    chk("arst_nov", 64'(out_valid), 64'd0);
    rst_n = 1'b1;
    sb_restart(64'h0);
    drive(1'b1, 1'b1, 1'b0, '0);
    cyc();
    look("arst_res0", 1'b1, 64'h0, 64'h4);
    cyc();
    look("arst_res1", 1'b1, 64'h4, 64'h8);

    drive(1'b0, 1'b0, 1'b0, '0);
    cyc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
